// File: rtl/store_pkg.sv
// Shared definitions for the store alignment unit: store-width encodings,
// FSM state type and the access-size helper.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } st_e;

  // Access size in bytes; funct3[2] is not a size bit and is screened separately.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane steering: places the low `size` bytes of data at byte
// offset `off` across a two-word window and returns the selected word.
module store_lane_shifter #(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] off,
  input  logic [3:0]       size,
  input  logic             beat_sel,
  output logic [XLEN-1:0]  wdata,
  output logic [NB-1:0]    be
);

  localparam int MW = 2 * NB;
  localparam int DW = 2 * XLEN;

  logic [MW-1:0]   mask_w;
  logic [MW-1:0]   be_w;
  logic [XLEN-1:0] data_m;
  logic [DW-1:0]   data_w;

  always_comb begin
    mask_w = (MW'(1) << size) - MW'(1);
    // Bytes above the access size are zeroed so disabled lanes stay 0.
    for (int i = 0; i < NB; i++) begin
      data_m[8*i +: 8] = mask_w[i] ? data[8*i +: 8] : 8'h00;
    end
    be_w   = mask_w << off;
    data_w = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
    wdata  = beat_sel ? data_w[DW-1:XLEN] : data_w[XLEN-1:0];
    be     = beat_sel ? be_w[MW-1:NB]     : be_w[NB-1:0];
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment engine: takes one store request per handshake and emits one
// or two word-aligned memory beats with lane-aligned data and byte enables.
module store_align_unit
  import store_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [XLEN-1:0]       req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_be,
  output logic                  busy,
  output logic                  store_err,
  output logic [1:0]            state_dbg
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer never drops valid or changes its payload before that edge;
  // ready may depend on state only, never on the partner's valid.

  st_e state_q, state_d;

  logic [XLEN-1:0]   data_q;
  logic [OFF_W-1:0]  off_q;
  logic [3:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic              cross_q;
  logic              err_q;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic              req_cross;
  logic              req_illegal;
  logic              req_reject;
  logic              accept;

  logic [XLEN-1:0]   sh_wdata;
  logic [NB-1:0]     sh_be;

  always_comb begin
    req_off     = req_addr[OFF_W-1:0];
    req_size    = size_bytes(req_funct3);
    req_cross   = (5'(req_off) + 5'(req_size)) > 5'(NB);
    // An access wider than the word (SD on a 32-bit unit) is illegal too.
    req_illegal = req_funct3[2] || (req_size > 4'(NB));
    req_reject  = req_illegal || (req_cross && !ALLOW_MISALIGNED);
    accept      = req_valid && req_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !req_reject) state_d = SEND0;
      SEND0:   if (mem_ready) state_d = cross_q ? SEND1 : IDLE;
      SEND1:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      base_q  <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && req_reject;
      if (accept && !req_reject) begin
        data_q  <= req_data;
        off_q   <= req_off;
        size_q  <= req_size;
        base_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        cross_q <= req_cross;
      end
    end
  end

  store_lane_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .data     (data_q),
    .off      (off_q),
    .size     (size_q),
    .beat_sel (state_q == SEND1),
    .wdata    (sh_wdata),
    .be       (sh_be)
  );

  // Beat payload comes only from request registers, so it is stable under stall.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_valid = (state_q != IDLE);
    busy      = mem_valid;
    store_err = err_q;
    state_dbg = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_valid) begin
      mem_addr  = (state_q == SEND1) ? base_q + ADDR_W'(NB) : base_q;
      mem_wdata = sh_wdata;
      mem_be    = sh_be;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: three instances (32-bit split, 32-bit reject,
// 64-bit split) behind one request/response mux selected by sel.
module tb_store_align_unit;
  import store_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        mem_ready;

  logic a_req_ready, a_mem_valid, a_busy, a_store_err;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [1:0]  a_state;
  logic b_req_ready, b_mem_valid, b_busy, b_store_err;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_state;
  logic c_req_ready, c_mem_valid, c_busy, c_store_err;
  logic [31:0] c_mem_addr;
  logic [63:0] c_mem_wdata;
  logic [7:0]  c_mem_be;
  logic [1:0]  c_state;

  logic        o_req_ready, o_mem_valid, o_busy, o_store_err;
  logic [31:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_be;
  logic [1:0]  o_state;

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 2'd0)), .req_ready(a_req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data[31:0]),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .busy(a_busy), .store_err(a_store_err),
    .state_dbg(a_state));

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 2'd1)), .req_ready(b_req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data[31:0]),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .busy(b_busy), .store_err(b_store_err),
    .state_dbg(b_state));

  store_align_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 2'd2)), .req_ready(c_req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(c_mem_valid), .mem_ready(mem_ready), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_be(c_mem_be), .busy(c_busy), .store_err(c_store_err),
    .state_dbg(c_state));

  always_comb begin
    o_req_ready = a_req_ready;
    o_mem_valid = a_mem_valid;
    o_busy      = a_busy;
    o_store_err = a_store_err;
    o_mem_addr  = a_mem_addr;
    o_mem_wdata = {32'h0, a_mem_wdata};
    o_mem_be    = {4'h0, a_mem_be};
    o_state     = a_state;
    case (sel)
      2'd1: begin
        o_req_ready = b_req_ready; o_mem_valid = b_mem_valid; o_busy = b_busy;
        o_store_err = b_store_err; o_mem_addr = b_mem_addr;
        o_mem_wdata = {32'h0, b_mem_wdata}; o_mem_be = {4'h0, b_mem_be}; o_state = b_state;
      end
      2'd2: begin
        o_req_ready = c_req_ready; o_mem_valid = c_mem_valid; o_busy = c_busy;
        o_store_err = c_store_err; o_mem_addr = c_mem_addr;
        o_mem_wdata = c_mem_wdata; o_mem_be = c_mem_be; o_state = c_state;
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Beat = {addr[31:0], wdata[63:0], be[7:0]}
  logic [103:0] exp_q[$];
  logic [103:0] obs_q[$];
  bit obs_err, obs_err_late, obs_idle, obs_timeout;
  int obs_unstable;

  function automatic logic [103:0] bt(input logic [31:0] a, input logic [63:0] w, input logic [7:0] b);
    return {a, w, b};
  endfunction

  // Reference: walk the store byte by byte and bin each byte by the word it lands in.
  task automatic model_store(input int nb, input bit allow, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [63:0] data,
                             output bit err, output int nbeats);
    logic [63:0] wd[2];
    logic [7:0]  be[2];
    logic [31:0] lowmask, w0, a, w;
    int size, lane, bi;
    wd[0] = '0; wd[1] = '0; be[0] = '0; be[1] = '0;
    size    = 1 << f3[1:0];
    lowmask = 32'(nb - 1);
    w0      = addr & ~lowmask;
    err     = f3[2] || (size > nb);
    nbeats  = 0;
    if (!err) begin
      nbeats = 1;
      for (int i = 0; i < size; i++) begin
        a    = addr + 32'(i);
        w    = a & ~lowmask;
        lane = int'(a - w);
        bi   = (w != w0) ? 1 : 0;
        if (bi == 1) nbeats = 2;
        wd[bi][lane*8 +: 8] = data[i*8 +: 8];
        be[bi][lane] = 1'b1;
      end
      if (nbeats == 2 && !allow) begin
        err = 1'b1;
        nbeats = 0;
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      exp_q.push_back({(b == 0) ? w0 : w0 + 32'(nb), wd[b], be[b]});
    end
  endtask

  // Driver/monitor: issue one request, hold off each beat for `stalls` cycles,
  // and record what appears on the selected unit's memory port.
  task automatic send_req(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [63:0] data, input int stalls);
    logic [103:0] snap;
    int guard;
    obs_q.delete();
    obs_unstable = 0;
    obs_timeout  = 1'b0;
    guard = 0;
    while (!o_req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!o_req_ready) obs_timeout = 1'b1;
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3; req_data = data;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    req_data   = {$urandom, $urandom};
    obs_err = o_store_err;
    guard = 0;
    while (o_mem_valid && guard < 100) begin
      snap = {o_mem_addr, o_mem_wdata, o_mem_be};
      for (int s = 0; s < stalls; s++) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
        if ({o_mem_addr, o_mem_wdata, o_mem_be} !== snap || !o_mem_valid || o_req_ready)
          obs_unstable++;
      end
      mem_ready = 1'b1;
      obs_q.push_back(snap);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      guard++;
    end
    if (guard >= 100) obs_timeout = 1'b1;
    obs_idle = o_req_ready && !o_busy && !o_mem_valid;
    if (obs_q.size() == 0) begin
      @(posedge clk); #1;
    end
    obs_err_late = o_store_err;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    req_addr = '0; req_funct3 = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", o_req_ready); else n_pass++;
    n_checks++; if (o_mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b exp 0", o_mem_valid); else n_pass++;
    n_checks++; if (o_mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h exp 0", o_mem_addr); else n_pass++;
    n_checks++; if (o_mem_wdata !== 64'h0) $display("FAIL reset_mem_wdata: got %h exp 0", o_mem_wdata); else n_pass++;
    n_checks++; if (o_mem_be !== 8'h0) $display("FAIL reset_mem_be: got %h exp 0", o_mem_be); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", o_busy); else n_pass++;
    n_checks++; if (o_store_err !== 1'b0) $display("FAIL reset_store_err: got %b exp 0", o_store_err); else n_pass++;
    n_checks++; if (o_state !== IDLE) $display("FAIL reset_state: got %0d exp %0d", o_state, IDLE); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]   sel;
    logic [31:0]  addr;
    logic [2:0]   f3;
    logic [63:0]  data;
    int           stalls;
    bit           err;
    int           nbeats;
    logic [103:0] b0;
    logic [103:0] b1;
  } case_t;

  task automatic test_directed();
    case_t tc[14];
    logic [63:0] d, d64;
    logic [103:0] exp_beat;
    d   = 64'h00000000_AABBCCDD;
    d64 = 64'h11223344_55667788;
    tc[0]  = '{2'd0, 32'h1000, F3_SW, d, 0, 1'b0, 1, bt(32'h1000, 64'hAABBCCDD, 8'h0F), '0};
    tc[1]  = '{2'd0, 32'h1003, F3_SB, d, 0, 1'b0, 1, bt(32'h1000, 64'hDD000000, 8'h08), '0};
    tc[2]  = '{2'd0, 32'h2002, F3_SH, d, 0, 1'b0, 1, bt(32'h2000, 64'hCCDD0000, 8'h0C), '0};
    tc[3]  = '{2'd0, 32'h1000, F3_SB, d, 1, 1'b0, 1, bt(32'h1000, 64'h000000DD, 8'h01), '0};
    tc[4]  = '{2'd0, 32'h2003, F3_SH, d, 0, 1'b0, 2, bt(32'h2000, 64'hDD000000, 8'h08),
               bt(32'h2004, 64'h000000CC, 8'h01)};
    tc[5]  = '{2'd0, 32'h3002, F3_SW, d, 3, 1'b0, 2, bt(32'h3000, 64'hCCDD0000, 8'h0C),
               bt(32'h3004, 64'h0000AABB, 8'h03)};
    tc[6]  = '{2'd0, 32'hFFFFFFFE, F3_SW, d, 1, 1'b0, 2, bt(32'hFFFFFFFC, 64'hCCDD0000, 8'h0C),
               bt(32'h00000000, 64'h0000AABB, 8'h03)};
    tc[7]  = '{2'd0, 32'h1000, F3_SD, d, 0, 1'b1, 0, '0, '0};
    tc[8]  = '{2'd0, 32'h1000, 3'b110, d, 0, 1'b1, 0, '0, '0};
    tc[9]  = '{2'd1, 32'h2003, F3_SH, d, 0, 1'b1, 0, '0, '0};
    tc[10] = '{2'd1, 32'h1000, F3_SW, d, 0, 1'b0, 1, bt(32'h1000, 64'hAABBCCDD, 8'h0F), '0};
    tc[11] = '{2'd2, 32'h104, F3_SD, d64, 2, 1'b0, 2, bt(32'h100, 64'h55667788_00000000, 8'hF0),
               bt(32'h108, 64'h00000000_11223344, 8'h0F)};
    tc[12] = '{2'd2, 32'h100, F3_SD, d64, 0, 1'b0, 1, bt(32'h100, 64'h11223344_55667788, 8'hFF), '0};
    tc[13] = '{2'd2, 32'h106, F3_SW, d, 0, 1'b0, 2, bt(32'h100, 64'hCCDD0000_00000000, 8'hC0),
               bt(32'h108, 64'h00000000_0000AABB, 8'h03)};
    for (int i = 0; i < 14; i++) begin
      sel = tc[i].sel;
      send_req(tc[i].addr, tc[i].f3, tc[i].data, tc[i].stalls);
      n_checks++; if (obs_err !== tc[i].err) $display("FAIL dir%0d_store_err: got %b exp %b", i, obs_err, tc[i].err); else n_pass++;
      n_checks++; if (obs_q.size() != tc[i].nbeats) $display("FAIL dir%0d_beat_count: got %0d exp %0d", i, obs_q.size(), tc[i].nbeats); else n_pass++;
      for (int b = 0; b < obs_q.size() && b < tc[i].nbeats; b++) begin
        exp_beat = (b == 0) ? tc[i].b0 : tc[i].b1;
        n_checks++; if (obs_q[b] !== exp_beat) $display("FAIL dir%0d_beat%0d: got %h exp %h", i, b, obs_q[b], exp_beat); else n_pass++;
      end
      n_checks++; if (obs_unstable != 0) $display("FAIL dir%0d_stall_stable: got %0d unstable cycles exp 0", i, obs_unstable); else n_pass++;
      n_checks++; if (!obs_idle || obs_err_late || obs_timeout)
        $display("FAIL dir%0d_idle_after: got idle=%b err_late=%b timeout=%b exp 1/0/0", i, obs_idle, obs_err_late, obs_timeout);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit e;
    int nb, nbeats;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [63:0] data;
    logic [103:0] exp_beat;
    for (int i = 0; i < 60; i++) begin
      sel  = 2'($urandom_range(0, 2));
      nb   = (sel == 2'd2) ? 8 : 4;
      f3   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr[31:4] = '1;
      data = {$urandom, $urandom};
      exp_q.delete();
      model_store(nb, sel != 2'd1, addr, f3, data, e, nbeats);
      send_req(addr, f3, data, $urandom_range(0, 2));
      n_checks++; if (obs_err !== e) $display("FAIL rnd%0d_store_err: got %b exp %b", i, obs_err, e); else n_pass++;
      n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_beat_count: got %0d exp %0d", i, obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        exp_beat = exp_q.pop_front();
        n_checks++; if (obs_q[0] !== exp_beat) $display("FAIL rnd%0d_beat: got %h exp %h", i, obs_q[0], exp_beat); else n_pass++;
        void'(obs_q.pop_front());
      end
      n_checks++; if (obs_unstable != 0) $display("FAIL rnd%0d_stall_stable: got %0d exp 0", i, obs_unstable); else n_pass++;
      n_checks++; if (!obs_idle || obs_err_late || obs_timeout)
        $display("FAIL rnd%0d_idle_after: got idle=%b err_late=%b timeout=%b exp 1/0/0", i, obs_idle, obs_err_late, obs_timeout);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[6];
    logic [2:0]  f3s[6];
    logic [63:0] data;
    logic [103:0] exp_beat;
    bit e, acc;
    int nbeats, exp_cyc, cyc, k;
    addrs = '{32'h1000, 32'h2003, 32'h1001, 32'h3002, 32'h4000, 32'h5004};
    f3s   = '{F3_SW, F3_SH, F3_SB, F3_SW, F3_SH, F3_SW};
    data  = 64'h00000000_13579BDF;
    sel = 2'd0;
    exp_q.delete(); obs_q.delete();
    exp_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      model_store(4, 1'b1, addrs[i], f3s[i], data, e, nbeats);
      exp_cyc += 1 + nbeats;
    end
    mem_ready = 1'b1;
    k = 0; cyc = 0;
    req_valid = 1'b1; req_addr = addrs[0]; req_funct3 = f3s[0]; req_data = data;
    while ((k < 6 || o_mem_valid) && cyc < 200) begin
      acc = req_valid && o_req_ready;
      if (o_mem_valid) obs_q.push_back({o_mem_addr, o_mem_wdata, o_mem_be});
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k < 6) begin
          req_addr = addrs[k]; req_funct3 = f3s[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0; mem_ready = 1'b0;
    n_checks++; if (cyc != exp_cyc) $display("FAIL b2b_cycles: got %0d exp %0d", cyc, exp_cyc); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
      exp_beat = exp_q[b];
      n_checks++; if (obs_q[b] !== exp_beat) $display("FAIL b2b_beat%0d: got %h exp %h", b, obs_q[b], exp_beat); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    sel = 2'd0;
    req_valid = 1'b1; req_addr = 32'h2003; req_funct3 = F3_SH; req_data = 64'hAABBCCDD;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_mem_addr !== 32'h2004 || !o_mem_valid) $display("FAIL mid_second_beat: got valid=%b addr=%h exp 1/00002004", o_mem_valid, o_mem_addr); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (o_mem_valid !== 1'b0) $display("FAIL mid_rst_mem_valid: got %b exp 0", o_mem_valid); else n_pass++;
    n_checks++; if (o_mem_be !== 8'h0) $display("FAIL mid_rst_mem_be: got %h exp 0", o_mem_be); else n_pass++;
    n_checks++; if (o_req_ready !== 1'b1) $display("FAIL mid_rst_req_ready: got %b exp 1", o_req_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_mem_valid !== 1'b0 || o_busy !== 1'b0) $display("FAIL mid_rst_no_partial: got valid=%b busy=%b exp 0/0", o_mem_valid, o_busy); else n_pass++;
    // Reset and an accept in the same cycle: reset wins.
    req_valid = 1'b1; req_addr = 32'h1000; req_funct3 = F3_SW; rst = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    n_checks++; if (o_mem_valid !== 1'b0 || o_store_err !== 1'b0) $display("FAIL rst_vs_accept: got valid=%b err=%b exp 0/0", o_mem_valid, o_store_err); else n_pass++;
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
